// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller and the
// pipeline registers it drives.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MWAIT  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  // addi x0, x0, 0 -- loaded by if_id / id_ex on a flush
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: the load in EX writes a register that the instruction
// in ID is about to read.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_load_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic [4:0] id_rs1_addr_i,
  input  logic       id_rs1_ren_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       id_rs2_ren_i,
  output logic       load_use_stall
);

  // x0 never carries a dependency, so a load targeting it cannot stall
  always_comb begin
    load_use_stall = 1'b0;
    if (ex_load_i && (ex_rd_addr_i != REG_ZERO)) begin
      load_use_stall = (id_rs1_ren_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                       (id_rs2_ren_i && (id_rs2_addr_i == ex_rd_addr_i));
    end else begin
      load_use_stall = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Front-end sequencing controller: owns every hold/flush/redirect decision for
// the IF -> ID -> EX pipeline, including multi-cycle EX and debug halt.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned MC_TIMEOUT   = 64,
  parameter int unsigned CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic        id_rs1_ren_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_rs2_ren_i,
  input  logic        ex_load_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        mc_req_i,
  input  logic        mc_done_i,
  input  logic        fetch_ready_i,
  input  logic        halt_req_i,
  output logic        halt_ack_o,
  output logic        hold_pc_o,
  output logic        hold_if_id_o,
  output logic        hold_id_ex_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        mc_timeout_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] MC_LAST    = CNT_W'(MC_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] save_q, save_d;
  logic             ret_drain_q, ret_drain_d;
  logic             halt_ack_q, halt_ack_d;
  logic             mc_timeout_q, mc_timeout_d;
  logic             load_use_stall;

  hazard_detect u_hazard_detect (
    .ex_load_i      (ex_load_i),
    .ex_rd_addr_i   (ex_rd_addr_i),
    .id_rs1_addr_i  (id_rs1_addr_i),
    .id_rs1_ren_i   (id_rs1_ren_i),
    .id_rs2_addr_i  (id_rs2_addr_i),
    .id_rs2_ren_i   (id_rs2_ren_i),
    .load_use_stall (load_use_stall)
  );

  // Next-state and combinational hold/flush/redirect outputs
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    save_d        = save_q;
    ret_drain_d   = ret_drain_q;
    halt_ack_d    = halt_ack_q;
    mc_timeout_d  = mc_timeout_q;
    hold_pc_o     = 1'b0;
    hold_if_id_o  = 1'b0;
    hold_id_ex_o  = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    jump_en_o     = 1'b0;
    jump_addr_o   = 32'd0;

    if (!rst_n) begin
      state_d = ST_RUN;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (jump_en_i) begin
            jump_en_o     = 1'b1;
            jump_addr_o   = jump_addr_i;
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
          end else if (mc_req_i) begin
            // done in the request cycle means a single-cycle op: nothing to wait for
            if (!mc_done_i) begin
              hold_pc_o    = 1'b1;
              hold_if_id_o = 1'b1;
              hold_id_ex_o = 1'b1;
              cnt_d        = CNT_ZERO;
              ret_drain_d  = 1'b0;
              state_d      = ST_MWAIT;
            end else begin
              state_d = ST_RUN;
            end
          end else if (load_use_stall) begin
            hold_pc_o     = 1'b1;
            hold_if_id_o  = 1'b1;
            flush_id_ex_o = 1'b1;
          end else if (halt_req_i) begin
            cnt_d   = CNT_ZERO;
            state_d = ST_DRAIN;
          end else if (!fetch_ready_i) begin
            hold_pc_o     = 1'b1;
            flush_if_id_o = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end

        ST_MWAIT: begin
          if (mc_done_i) begin
            ret_drain_d = 1'b0;
            if (ret_drain_q) begin
              cnt_d   = save_q;
              state_d = ST_DRAIN;
            end else begin
              cnt_d   = CNT_ZERO;
              state_d = ST_RUN;
            end
          end else if (cnt_q == MC_LAST) begin
            // abandon the op: EX is squashed, the front end stays put one more cycle
            hold_pc_o     = 1'b1;
            hold_if_id_o  = 1'b1;
            flush_id_ex_o = 1'b1;
            mc_timeout_d  = 1'b1;
            ret_drain_d   = 1'b0;
            cnt_d         = CNT_ZERO;
            state_d       = ST_RUN;
          end else begin
            hold_pc_o    = 1'b1;
            hold_if_id_o = 1'b1;
            hold_id_ex_o = 1'b1;
            cnt_d        = cnt_q + CNT_ONE;
          end
        end

        ST_DRAIN: begin
          hold_pc_o     = 1'b1;
          flush_if_id_o = 1'b1;
          if (jump_en_i) begin
            jump_en_o     = 1'b1;
            jump_addr_o   = jump_addr_i;
            flush_id_ex_o = 1'b1;
          end else begin
            jump_en_o = 1'b0;
          end
          if (!halt_req_i) begin
            cnt_d   = CNT_ZERO;
            state_d = ST_RUN;
          end else if (mc_req_i && !mc_done_i && !jump_en_i) begin
            // park the drain count while EX finishes its op, then resume draining
            hold_id_ex_o = 1'b1;
            ret_drain_d  = 1'b1;
            save_d       = cnt_q;
            cnt_d        = CNT_ZERO;
            state_d      = ST_MWAIT;
          end else if (cnt_q == DRAIN_LAST) begin
            cnt_d   = CNT_ZERO;
            state_d = ST_HALTED;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_HALTED: begin
          hold_pc_o     = 1'b1;
          flush_if_id_o = 1'b1;
          if (!halt_req_i) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_HALTED;
          end
        end

        default: begin
          state_d = ST_RUN;
          cnt_d   = CNT_ZERO;
        end
      endcase
      halt_ack_d = (state_d == ST_HALTED);
    end
  end

  // State, counter and registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      cnt_q        <= CNT_ZERO;
      save_q       <= CNT_ZERO;
      ret_drain_q  <= 1'b0;
      halt_ack_q   <= 1'b0;
      mc_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      save_q       <= save_d;
      ret_drain_q  <= ret_drain_d;
      halt_ack_q   <= halt_ack_d;
      mc_timeout_q <= mc_timeout_d;
    end
  end

  assign halt_ack_o   = halt_ack_q;
  assign mc_timeout_o = mc_timeout_q;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 3-stage core (IF → ID → EX). It owns every hold/flush/bubble decision for the front end: branch/jump redirect, load-use stalls against the decode stage's source registers, multi-cycle EX operations, instruction-fetch wait, and a debug halt/resume handshake. It sits beside the pipeline registers (`pc_reg`, `if_id`, `id_ex`) and drives their hold/flush inputs. It replaces ad-hoc hold logic spread across stages.

## Interface
- `DRAIN_CYCLES`, default 3: cycles of bubble injection before a halt is acknowledged.
- `MC_TIMEOUT`, default 64: maximum MWAIT cycles before abort.
- `CNT_W`, default 8: width of the shared cycle counter; must satisfy 2^CNT_W > MC_TIMEOUT.
- `clk  in  1`: core clock.
- `rst_n  in  1`: reset is asynchronous and active-low. While low, all outputs are 0 and state is RUN.
- `jump_en_i  in  1`: EX resolved a taken branch or jump.
- `jump_addr_i  in  32`: target address.
- `id_rs1_addr_i  in  5`, `id_rs1_ren_i  in  1`: ID source 1 and its read enable.
- `id_rs2_addr_i  in  5`, `id_rs2_ren_i  in  1`: ID source 2 and its read enable.
- `ex_load_i  in  1`: instruction in EX is a load.
- `ex_rd_addr_i  in  5`: destination register of the instruction in EX.
- `mc_req_i  in  1`: EX starts a multi-cycle operation (divider).
- `mc_done_i  in  1`: multi-cycle result valid this cycle.
- `fetch_ready_i  in  1`: instruction bus returned valid data this cycle.
- `halt_req_i  in  1`: debug halt request, level-sensitive.
- `halt_ack_o  out  1`: registered; core is halted.
- `hold_pc_o`, `hold_if_id_o`, `hold_id_ex_o  out  1`: freeze the corresponding register.
- `flush_if_id_o`, `flush_id_ex_o  out  1`: load NOP into the corresponding register.
- `jump_en_o  out  1`, `jump_addr_o  out  32`: PC redirect. At `pc_reg`, `jump_en_o` has priority over `hold_pc_o`.
- `mc_timeout_o  out  1`: registered and sticky; cleared only by reset.

## Operation
- States: RUN, MWAIT, DRAIN, HALTED. A 1-bit `ret_drain` records whether MWAIT was entered from DRAIN.
- Outputs are combinational from state and inputs, except `halt_ack_o` and `mc_timeout_o`.
- Priority inside RUN, highest first:
  1. **Jump:** if `jump_en_i`, assert `jump_en_o`, `jump_addr_o`=`jump_addr_i`, `flush_if_id_o`, `flush_id_ex_o`. `mc_req_i` and `halt_req_i` are ignored this cycle.
  2. **Multi-cycle:** if `mc_req_i` and not `mc_done_i`, assert all three holds, clear the counter, go to MWAIT. If `mc_done_i` is also high, it is a single-cycle op: no holds, stay in RUN.
  3. **Load-use:** if `ex_load_i`, `ex_rd_addr_i`≠0, and (`rs1_ren` & rs1==rd, or `rs2_ren` & rs2==rd), assert `hold_pc_o`, `hold_if_id_o`, `flush_id_ex_o` for exactly that cycle.
  4. **Halt:** if `halt_req_i`, clear the counter and go to DRAIN.
  5. **Fetch wait:** if not `fetch_ready_i`, assert `hold_pc_o` and `flush_if_id_o`.
- **MWAIT:**
  - While `mc_done_i`=0, hold all three registers and increment the counter.
  - On `mc_done_i`=1, drop the holds that cycle and go to RUN, or to DRAIN if `ret_drain`; in the DRAIN case the counter is restored.
  - When the counter reaches MC_TIMEOUT−1 without done: set `mc_timeout_o`, assert `flush_id_ex_o` that cycle, and go to RUN.
- **DRAIN:**
  - Assert `hold_pc_o` and `flush_if_id_o` every cycle; increment the counter.
  - After DRAIN_CYCLES cycles, go to HALTED and set `halt_ack_o`.
  - `jump_en_i` in DRAIN is forwarded with both flushes; it does not restart the count.
  - `mc_req_i` in DRAIN: set `ret_drain`, save the count, go to MWAIT.
  - `halt_req_i` falling in DRAIN: go to RUN, no ack.
- **HALTED:** assert `hold_pc_o` and `flush_if_id_o`. When `halt_req_i`=0, go to RUN and clear `halt_ack_o` on the same edge.

## Timing
- Jump, load-use and fetch-wait responses are zero-latency, combinational in the same cycle.
- The MWAIT transition takes effect at the next edge. Holds are asserted in the request cycle itself, so EX keeps its instruction.
- `halt_ack_o` rises DRAIN_CYCLES+1 edges after `halt_req_i` is first seen in RUN with no higher-priority event. It falls one edge after `halt_req_i` falls.
- `mc_timeout_o` rises at the edge ending MWAIT cycle MC_TIMEOUT.
- Reset asserted mid-MWAIT or mid-DRAIN immediately zeroes all outputs, the counter and `ret_drain`.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - the state enum encoding (RUN=0, MWAIT=1, DRAIN=2, HALTED=3);
  - the `REG_ZERO` constant;
  - the NOP flush value shared with `if_id`/`id_ex`.
- Sub-module `hazard_detect`: purely combinational load-use comparator producing `load_use_stall`.

## Test plan
- **Load-use:** ex_load=1, ex_rd=5, id_rs2=5, rs2_ren=1 → hold_pc=hold_if_id=flush_id_ex=1 for 1 cycle. With ex_rd=0 → no stall.
- **Jump over stall:** jump_en=1, addr=0x100, while mc_req=1 → jump_en_o=1, jump_addr_o=0x100, both flushes=1, state stays RUN.
- **Multi-cycle:** mc_req at cycle 0, mc_done at cycle 5 → holds high for cycles 0–4, low at 5, RUN at edge 6.
- **Timeout:** mc_req with no done, MC_TIMEOUT=8 → mc_timeout_o=1 after the 8th MWAIT cycle, flush_id_ex pulses, RUN; the flag stays high until rst_n=0.
- **Halt round-trip:** halt_req rises at cycle 0, DRAIN_CYCLES=3 → halt_ack=1 at edge 4; halt_req falls → ack=0 at the next edge and holds released.
- **Reset mid-MWAIT:** rst_n=0 during MWAIT → all outputs 0 immediately; after release, state is RUN with the counter at 0.
